npu_dram_model: RTL
===================

# npu_dram_model

Parametrised, multi-port off-chip memory model for NPU simulation and emulation builds. It replaces the single-port, fixed one-cycle DRAM stand-in with a configurable number of requestor ports, such as NPU load/store and instruction fetch. Ports share one storage array through a round-robin arbiter with a valid/ready request handshake. The block adds byte-masked writes and a configurable read latency; read responses are tagged by port.

## Interface
Parameters:
- AWIDTH, 10, word address width; depth is 2^AWIDTH words
- DWIDTH, 80, data word width; must be a multiple of 8
- NUM_PORTS, 2, number of requestor ports, 1..8
- RD_LATENCY, 2, cycles from request handshake to read response, at least 1

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset_npu  in  1  reset, synchronous, active-low
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port grant; one-hot or zero
- req_we  in  NUM_PORTS  per-port request type: 1 = write, 0 = read
- req_addr  in  NUM_PORTS*AWIDTH  per-port word address; port i uses slice [i*AWIDTH +: AWIDTH]
- req_wdata  in  NUM_PORTS*DWIDTH  per-port write data
- req_be  in  NUM_PORTS*DWIDTH/8  per-port byte enables; bit b covers data bits [8b+7:8b]
- rsp_valid  out  NUM_PORTS  one-hot read-response strobe; the set bit identifies the port the data belongs to
- rsp_data  out  DWIDTH  read data, shared by all ports

## Operation
- A handshake on port i occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
- At most one handshake occurs per cycle.
- Arbiter:
  - req_ready is combinational from req_valid and the priority pointer `ptr`.
  - The grant goes to the first valid port found searching i = ptr, ptr+1, … modulo NUM_PORTS.
  - When no port is valid, req_ready is 0.
  - After a handshake on port g, `ptr` becomes (g+1) mod NUM_PORTS; with no handshake, `ptr` is held.
  - Requestors must hold valid and payload stable until the handshake.
- Write: at the handshake edge, each byte b with req_be bit b set is written. Other bytes keep their contents. A write with be = 0 changes nothing. Writes produce no response.
- Read:
  - At the handshake edge, the array word is captured with the port id.
  - The word and id travel through an RD_LATENCY-stage valid/data/id pipeline.
  - The final stage drives rsp_valid (one-hot id) and rsp_data.
  - No response backpressure: the requestor must accept rsp_valid whenever it asserts.
- Read data is a snapshot at the handshake edge. A write to the same address accepted in any later cycle does not change an in-flight response.
- Read after write, any ports: a read handshaking in the cycle after a write handshake returns the new data.
- Out-of-range addresses are impossible; address width equals the array depth.
- Memory contents are not initialised or cleared by reset. A simulation-only $readmemh initial load of a plusarg-named file is allowed.

## Timing
- Reset (reset_npu = 0 at an edge):
  - `ptr` goes to 0 and all pipeline valids clear.
  - rsp_valid = 0 and rsp_data = 0 from the next cycle.
  - req_ready = 0 while reset_npu = 0.
  - In-flight reads are dropped.
  - A write presented during reset is not committed.
- A read handshake in cycle T gives rsp_valid in cycle T+RD_LATENCY for exactly one cycle.
- Back-to-back reads give back-to-back responses in request order. Sustained throughput is 1 access per cycle.
- rsp_data is 0 in cycles where rsp_valid = 0.
- Simultaneous requests from all ports are each granted within NUM_PORTS cycles; no port starves.
- RD_LATENCY = 1: the response is the registered array output, with no extra stages.

## Test plan
- Reset: hold reset_npu = 0 with req_valid = all ones → req_ready = 0, rsp_valid = 0, rsp_data = 0. Release → port 0 is granted first.
- Write/read, RD_LATENCY = 2:
  - Port 0 writes addr 5 = 0x0102030405060708090A with be all ones in cycle T.
  - Port 1 reads addr 5 in cycle T+1.
  - Required: rsp_valid = 2'b10 in cycle T+3 with that data, and nothing else.
- Byte mask:
  - Addr 7 holds 0xFF…FF; write 0x00…00 with be = 10'b0000000011 → a read returns 0xFF…FF0000.
  - Write with be = 0 → the value is unchanged.
- Arbitration, NUM_PORTS = 3: all ports hold valid with reads for 6 cycles → grants cycle 0,1,2,0,1,2 and responses in that order, each RD_LATENCY later.
- Snapshot:
  - Read addr 9 (old value 0x11) in cycle T; write addr 9 = 0x22 in cycle T+1.
  - Required: the response at T+RD_LATENCY = 0x11; a new read returns 0x22.
- Reset mid-flight: issue 2 reads, assert reset one cycle later for 1 cycle → no rsp_valid ever appears for those reads; a subsequent read returns normally.

Source files
------------

// File: rtl/npu_dram_model.sv
// Multi-port word-addressed memory model: round-robin arbitration over one shared
// array, byte-masked writes and a fixed-latency, port-tagged read response pipeline.
module npu_dram_model #(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = 80,
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            reset_npu,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*AWIDTH-1:0]     req_addr,
  input  logic [NUM_PORTS*DWIDTH-1:0]     req_wdata,
  input  logic [NUM_PORTS*DWIDTH/8-1:0]   req_be,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DWIDTH-1:0]               rsp_data
);

  localparam int NB    = DWIDTH / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 1 << AWIDTH;

  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     ptr_d;
  logic [PW-1:0]     grantIdx;
  logic [PW-1:0]     scanIdx;
  logic              grantAny;
  int                scanSum;

  logic              selWe;
  logic [AWIDTH-1:0] selAddr;
  logic [DWIDTH-1:0] selWdata;
  logic [NB-1:0]     selBe;
  logic              doWrite;
  logic              doRead;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [RD_LATENCY-1:0] vld_q;
  logic [PW-1:0]         id_q   [RD_LATENCY];
  logic [DWIDTH-1:0]     data_q [RD_LATENCY];

  // Rotating priority search starting at ptr; nothing is granted while in reset.
  always_comb begin
    req_ready = '0;
    grantIdx  = '0;
    grantAny  = 1'b0;
    scanSum   = 0;
    scanIdx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scanSum = int'(ptr_q) + k;
      if (scanSum >= NUM_PORTS) scanSum = scanSum - NUM_PORTS;
      scanIdx = PW'(scanSum);
      if (!grantAny && reset_npu && req_valid[scanIdx]) begin
        grantAny = 1'b1;
        grantIdx = scanIdx;
      end
    end
    if (grantAny) req_ready[grantIdx] = 1'b1;
  end

  always_comb begin
    selWe    = req_we[grantIdx];
    selAddr  = req_addr[int'(grantIdx)*AWIDTH +: AWIDTH];
    selWdata = req_wdata[int'(grantIdx)*DWIDTH +: DWIDTH];
    selBe    = req_be[int'(grantIdx)*NB +: NB];
    doWrite  = grantAny && selWe;
    doRead   = grantAny && !selWe;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grantAny) begin
      if (grantIdx == PW'(NUM_PORTS - 1)) ptr_d = '0;
      else                                ptr_d = grantIdx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_npu) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  // Storage is deliberately left out of reset; contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int b = 0; b < NB; b++) begin
        if (selBe[b]) mem_q[selAddr][8*b +: 8] <= selWdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_npu) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= doRead;
      for (int s = 1; s < RD_LATENCY; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  // Payload stages carry no reset; the valid chain alone qualifies them.
  always_ff @(posedge clk) begin
    if (doRead) begin
      data_q[0] <= mem_q[selAddr];
      id_q[0]   <= grantIdx;
    end
    for (int s = 1; s < RD_LATENCY; s++) begin
      data_q[s] <= data_q[s-1];
      id_q[s]   <= id_q[s-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (vld_q[RD_LATENCY-1]) begin
      rsp_valid[id_q[RD_LATENCY-1]] = 1'b1;
      rsp_data                      = data_q[RD_LATENCY-1];
    end
  end

endmodule
